// File: rtl/biquad8_coeff_sequencer.sv
// rtl/biquad8_coeff_sequencer.sv - shadow coefficient store streamed into the biquad8 cascade chain
// Host writes fill the shadow; a commit streams it high index first, then strobes the B2 load.
module biquad8_coeff_sequencer #(
  parameter int NSAMP = 8,
  parameter int CBITS = 18
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 wr_valid_i,
  output logic                                 wr_ready_o,
  input  logic [$clog2(2*(NSAMP-2))-1:0]       wr_addr_i,
  input  logic [CBITS-1:0]                     wr_dat_i,
  input  logic                                 commit_i,
  output logic                                 busy_o,
  output logic                                 done_o,
  output logic                                 addr_err_o,
  output logic [15:0]                          update_count_o,
  output logic [CBITS-1:0]                     coeff_dat_o,
  output logic                                 coeff_wr_o,
  output logic                                 coeff_update_o
);

  localparam int NCOEFF = 2 * (NSAMP - 2);
  localparam int AW = $clog2(NCOEFF);
  localparam logic [AW-1:0] LAST = AW'(NCOEFF - 1);

  typedef enum logic [1:0] {IDLE, LOAD, UPDATE, DONE} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic             pending_q, pending_d;
  logic [CBITS-1:0] shadow_q [NCOEFF];

  logic             wr_ready_q, wr_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             addr_err_q, addr_err_d;
  logic [15:0]      count_q, count_d;
  logic [CBITS-1:0] coeff_dat_q, coeff_dat_d;
  logic             coeff_wr_q, coeff_wr_d;
  logic             coeff_update_q, coeff_update_d;
  logic             wr_accept;

  assign wr_accept = wr_valid_i & wr_ready_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
    end
  end

  // A commit that arrived while busy is replayed straight from DONE (or from IDLE if it landed in DONE).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (commit_i || pending_q) state_d = LOAD;
      LOAD:    if (cnt_q == '0) state_d = UPDATE;
      UPDATE:  state_d = DONE;
      DONE:    state_d = pending_q ? LOAD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_q != LOAD && state_d == LOAD) begin
      cnt_d = LAST;
    end else if (state_q == LOAD && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end

    pending_d = pending_q;
    if (state_q != LOAD && state_d == LOAD) begin
      pending_d = 1'b0;
    end else if (commit_i && state_q != IDLE) begin
      pending_d = 1'b1;
    end

    wr_ready_d     = (state_d == IDLE);
    busy_d         = (state_d != IDLE);
    done_d         = (state_d == DONE);
    coeff_wr_d     = (state_d == LOAD);
    coeff_update_d = (state_d == UPDATE);
    addr_err_d     = wr_accept && (wr_addr_i > LAST);
    count_d        = (state_d == DONE) ? count_q + 16'd1 : count_q;
    // Data trails the shift enable by one cycle; the down-counter doubles as the read index.
    coeff_dat_d    = coeff_wr_q ? shadow_q[cnt_q] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ready_q     <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      addr_err_q     <= 1'b0;
      count_q        <= '0;
      coeff_dat_q    <= '0;
      coeff_wr_q     <= 1'b0;
      coeff_update_q <= 1'b0;
    end else begin
      wr_ready_q     <= wr_ready_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      addr_err_q     <= addr_err_d;
      count_q        <= count_d;
      coeff_dat_q    <= coeff_dat_d;
      coeff_wr_q     <= coeff_wr_d;
      coeff_update_q <= coeff_update_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NCOEFF; k++) shadow_q[k] <= '0;
    end else if (wr_accept && wr_addr_i <= LAST) begin
      shadow_q[wr_addr_i] <= wr_dat_i;
    end
  end

  assign wr_ready_o     = wr_ready_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign addr_err_o     = addr_err_q;
  assign update_count_o = count_q;
  assign coeff_dat_o    = coeff_dat_q;
  assign coeff_wr_o     = coeff_wr_q;
  assign coeff_update_o = coeff_update_q;

endmodule

// File: tb/tb_biquad8_coeff_sequencer.sv
// tb/tb_biquad8_coeff_sequencer.sv - directed self-checking bench for biquad8_coeff_sequencer
module tb_biquad8_coeff_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid_i;
  logic        wr_ready_o;
  logic [3:0]  wr_addr_i;
  logic [17:0] wr_dat_i;
  logic        commit_i;
  logic        busy_o;
  logic        done_o;
  logic        addr_err_o;
  logic [15:0] update_count_o;
  logic [17:0] coeff_dat_o;
  logic        coeff_wr_o;
  logic        coeff_update_o;

  int          checks = 0;
  int          errors = 0;
  int          exp_cnt = 0;
  logic [17:0] model [12];

  biquad8_coeff_sequencer dut (
    .clk(clk), .rst(rst),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
    .wr_addr_i(wr_addr_i), .wr_dat_i(wr_dat_i),
    .commit_i(commit_i), .busy_o(busy_o), .done_o(done_o),
    .addr_err_o(addr_err_o), .update_count_o(update_count_o),
    .coeff_dat_o(coeff_dat_o), .coeff_wr_o(coeff_wr_o),
    .coeff_update_o(coeff_update_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [17:0] d);
    wr_valid_i = 1'b1;
    wr_addr_i  = a;
    wr_dat_i   = d;
    tick();
    wr_valid_i = 1'b0;
    if (a < 4'd12) model[a] = d;
  endtask

  // Commit at offset 0; c1/c2 are extra commit offsets (0 = none).
  task automatic stream_check(input int c1, input int c2, input bit hold_wr, input bit same_wr);
    int nseq, last, s, rel;
    nseq = (c1 > 0 || c2 > 0) ? 2 : 1;
    last = (nseq == 2) ? 28 : 14;
    commit_i = 1'b1;
    if (same_wr) begin
      wr_valid_i = 1'b1;
      wr_addr_i  = 4'd11;
      wr_dat_i   = 18'h1FFFF;
      model[11]  = 18'h1FFFF;
    end
    tick();
    commit_i   = 1'b0;
    wr_valid_i = 1'b0;
    if (hold_wr) begin
      wr_valid_i = 1'b1;
      wr_addr_i  = 4'd3;
      wr_dat_i   = 18'h2AAAA;
    end
    for (int off = 1; off <= last; off++) begin
      s   = (nseq == 2 && off > 14) ? 14 : 0;
      rel = off - s;
      check("wr", coeff_wr_o, (rel >= 1 && rel <= 12));
      check("dat", coeff_dat_o, (rel >= 2 && rel <= 13) ? model[13-rel] : 18'h0);
      check("upd", coeff_update_o, rel == 13);
      check("done", done_o, rel == 14);
      check("busy", busy_o, 1'b1);
      check("ready_busy", wr_ready_o, 1'b0);
      commit_i = (off == c1 || off == c2);
      tick();
    end
    commit_i = 1'b0;
    exp_cnt  = exp_cnt + nseq;
    check("idle_busy", busy_o, 1'b0);
    check("idle_ready", wr_ready_o, 1'b1);
    check("count", update_count_o, exp_cnt);
  endtask

  initial begin
    rst = 1'b1; wr_valid_i = 1'b0; wr_addr_i = '0; wr_dat_i = '0; commit_i = 1'b0;
    for (int k = 0; k < 12; k++) model[k] = '0;
    tick(); tick();
    check("rst_ready", wr_ready_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_wr", coeff_wr_o, 1'b0);
    check("rst_dat", coeff_dat_o, 18'h0);
    check("rst_count", update_count_o, 16'h0);
    rst = 1'b0;
    tick();
    check("post_rst_ready", wr_ready_o, 1'b1);

    for (int k = 0; k < 12; k++) wr(k[3:0], 18'(k + 1));
    check("no_err", addr_err_o, 1'b0);
    stream_check(0, 0, 1'b0, 1'b0);

    stream_check(5, 7, 1'b0, 1'b0);

    stream_check(0, 0, 1'b1, 1'b0);
    tick();
    wr_valid_i = 1'b0;
    model[3] = 18'h2AAAA;
    stream_check(0, 0, 1'b0, 1'b0);

    wr(4'd12, 18'h12345);
    check("err12", addr_err_o, 1'b1);
    tick();
    check("err12_clr", addr_err_o, 1'b0);
    wr(4'd15, 18'h3FFFF);
    check("err15", addr_err_o, 1'b1);
    tick();
    check("err15_clr", addr_err_o, 1'b0);
    stream_check(0, 0, 1'b0, 1'b0);

    stream_check(0, 0, 1'b0, 1'b1);

    commit_i = 1'b1;
    tick();
    commit_i = 1'b0;
    repeat (5) tick();
    check("mid_wr", coeff_wr_o, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("abort_wr", coeff_wr_o, 1'b0);
    check("abort_dat", coeff_dat_o, 18'h0);
    check("abort_upd", coeff_update_o, 1'b0);
    check("abort_busy", busy_o, 1'b0);
    check("abort_count", update_count_o, 16'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_done", done_o, 1'b0);
    end
    rst = 1'b0;
    tick();
    check("abort_upd2", coeff_update_o, 1'b0);
    check("abort_ready", wr_ready_o, 1'b1);
    for (int k = 0; k < 12; k++) model[k] = '0;
    exp_cnt = 0;
    stream_check(0, 0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
